// File: rtl/lvds_frame_tx.sv
// lvds_frame_tx: ADC-style LVDS framer/serializer, two bits per dco cycle per lane, MSB first.
// Defining LVDS_TX_PATTERN_EN adds the internal ramp/alternate/midscale pattern source.
module lvds_frame_tx #(
    parameter int LANES = 8,
    parameter int BITS  = 14
) (
    input  logic                    i_dco,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [LANES*BITS-1:0]   i_din,
    input  logic                    i_din_valid,
    output logic                    o_din_ready,
    input  logic [1:0]              i_pat_mode,
    output logic [LANES-1:0]        o_d1,
    output logic [LANES-1:0]        o_d2,
    output logic                    o_fco1,
    output logic                    o_fco2,
    output logic                    o_frame_start,
    output logic                    o_underrun
);
    localparam int SLOTS = BITS / 2;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_s_nxt;
    logic            w_load;
    logic            w_pass;
    logic [BITS-1:0] r_shift [LANES];
    logic [BITS-1:0] r_hold  [LANES];
    logic [BITS-1:0] w_word  [LANES];

    // Frame clock is high while the bit index within the frame is below BITS/2.
    function automatic logic [1:0] fco_bits(input logic [SW-1:0] k);
        int idx;
        idx = 2 * int'(k);
        return {(idx < SLOTS), ((idx + 1) < SLOTS)};
    endfunction

`ifdef LVDS_TX_PATTERN_EN
    function automatic logic [BITS-1:0] alt_word(input logic odd_set);
        logic [BITS-1:0] w;
        for (int j = 0; j < BITS; j++) begin
            w[j] = ((j % 2) == 1) ? odd_set : ~odd_set;
        end
        return w;
    endfunction

    localparam logic [BITS-1:0] ALT_A = alt_word(1'b1);
    localparam logic [BITS-1:0] ALT_B = alt_word(1'b0);
    localparam logic [BITS-1:0] MID   = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS-1:0] r_cnt;
    logic            r_alt;

    assign w_pass = (i_pat_mode == 2'd0);

    // Word to load: din, the held word on underrun, or a pattern word.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_word[i] = r_hold[i];
            case (i_pat_mode)
                2'd0:    w_word[i] = i_din_valid ? i_din[i*BITS +: BITS] : r_hold[i];
                2'd1:    w_word[i] = r_cnt + BITS'(i);
                2'd2:    w_word[i] = r_alt ? ALT_B : ALT_A;
                2'd3:    w_word[i] = MID;
                default: w_word[i] = r_hold[i];
            endcase
        end
    end

    // Ramp counter and alternate phase advance once per frame of their own mode.
    always_ff @(posedge i_dco) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_alt <= 1'b0;
        end else if (w_load) begin
            if (i_pat_mode == 2'd1) r_cnt <= r_cnt + {{(BITS-1){1'b0}}, 1'b1};
            if (i_pat_mode == 2'd2) r_alt <= ~r_alt;
        end
    end
`else
    logic w_unused_pat;

    assign w_pass       = 1'b1;
    assign w_unused_pat = ^i_pat_mode;

    // Word to load: din, or the held word on underrun.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_word[i] = i_din_valid ? i_din[i*BITS +: BITS] : r_hold[i];
        end
    end
`endif

    assign o_din_ready = w_load & w_pass & ~i_rst;

    // Next state and slot; a load happens on IDLE+en or last slot+en.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_nxt = '0;
                if (i_en) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_s == LAST) begin
                    w_s_nxt = '0;
                    if (i_en) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_s_nxt     = r_s + SW'(1);
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = '0;
            end
        endcase
    end

    // State, slot counter and sticky underrun flag.
    always_ff @(posedge i_dco) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            o_underrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            if (w_load && w_pass && !i_din_valid) o_underrun <= 1'b1;
        end
    end

    // Serial outputs: registered slot bits of the word in flight, zero when idle.
    always_ff @(posedge i_dco) begin
        if (i_rst) begin
            o_d1          <= '0;
            o_d2          <= '0;
            o_fco1        <= 1'b0;
            o_fco2        <= 1'b0;
            o_frame_start <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_shift[i] <= '0;
                r_hold[i]  <= '0;
            end
        end else begin
            o_frame_start <= w_load;
            if (w_state_nxt == ST_RUN) begin
                {o_fco1, o_fco2} <= fco_bits(w_s_nxt);
            end else begin
                {o_fco1, o_fco2} <= 2'b00;
            end
            for (int i = 0; i < LANES; i++) begin
                if (w_load) begin
                    o_d1[i]    <= w_word[i][BITS-1];
                    o_d2[i]    <= w_word[i][BITS-2];
                    r_shift[i] <= w_word[i] << 2;
                    if (w_pass && i_din_valid) r_hold[i] <= i_din[i*BITS +: BITS];
                end else if (w_state_nxt == ST_RUN) begin
                    o_d1[i]    <= r_shift[i][BITS-1];
                    o_d2[i]    <= r_shift[i][BITS-2];
                    r_shift[i] <= r_shift[i] << 2;
                end else begin
                    o_d1[i] <= 1'b0;
                    o_d2[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lvds_frame_tx.sv
// Self-checking bench for lvds_frame_tx: directed frames plus randomized frames against a
// frame-level reference model (expected word per frame, bit/frame-clock rules per slot).
module tb_lvds_frame_tx;
    localparam int LANES = 8;
    localparam int BITS  = 14;
    localparam int SLOTS = BITS / 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [LANES*BITS-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic [1:0]            pat_mode;
    logic [LANES-1:0]      d1;
    logic [LANES-1:0]      d2;
    logic                  fco1;
    logic                  fco2;
    logic                  frame_start;
    logic                  underrun;

    int tests = 0;
    int fails = 0;

    logic [BITS-1:0] m_prev  [LANES];
    logic [BITS-1:0] m_frame [LANES];
    logic            m_underrun;
    int              m_cnt;
    logic            m_alt;

    lvds_frame_tx #(.LANES(LANES), .BITS(BITS)) dut (
        .i_dco(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(din_valid),
        .o_din_ready(din_ready), .i_pat_mode(pat_mode), .o_d1(d1), .o_d2(d2),
        .o_fco1(fco1), .o_fco2(fco2), .o_frame_start(frame_start), .o_underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*BITS-1:0] rand_din();
        logic [LANES*BITS-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*BITS +: BITS] = BITS'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) m_prev[i] = '0;
        m_underrun = 1'b0;
        m_cnt      = 0;
        m_alt      = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {d1, d2, fco1, fco2, frame_start, underrun}, {20'h0, m_underrun});
    endtask

    // Drive a load cycle and compute the word each lane must send next.
    task automatic load(input logic valid, input logic [LANES*BITS-1:0] data, input logic [1:0] mode);
        logic pass;
`ifdef LVDS_TX_PATTERN_EN
        pass = (mode == 2'd0);
`else
        pass = 1'b1;
`endif
        en = 1'b1; din_valid = valid; din = data; pat_mode = mode;
        #1;
        chk("din_ready_load", din_ready, pass);
        for (int i = 0; i < LANES; i++) begin
            if (pass) begin
                if (valid) m_prev[i] = data[i*BITS +: BITS];
                m_frame[i] = m_prev[i];
            end else if (mode == 2'd1) begin
                m_frame[i] = BITS'((m_cnt + i) % (1 << BITS));
            end else if (mode == 2'd2) begin
                m_frame[i] = m_alt ? 14'h1555 : 14'h2AAA;
            end else begin
                m_frame[i] = 14'h2000;
            end
        end
        if (pass && !valid) m_underrun = 1'b1;
        if (!pass && mode == 2'd1) m_cnt = (m_cnt + 1) % (1 << BITS);
        if (!pass && mode == 2'd2) m_alt = ~m_alt;
    endtask

    // Check one frame slot by slot; returns at the last slot, or early with rst raised.
    task automatic run_frame(input int stop_slot, input int rst_slot, input logic directed);
        logic [13:0]      pairs;
        logic [LANES-1:0] e1;
        logic [LANES-1:0] e2;
        pairs = 14'b10_11_01_01_01_10_10;
        for (int k = 0; k < SLOTS; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < LANES; i++) begin
                e1[i] = m_frame[i][BITS-1-2*k];
                e2[i] = m_frame[i][BITS-2-2*k];
            end
            chk("d1", d1, e1);
            chk("d2", d2, e2);
            chk("fco", {fco1, fco2}, {(2*k < SLOTS), (2*k+1 < SLOTS)});
            chk("frame_start", frame_start, (k == 0));
            chk("underrun", underrun, m_underrun);
            if (directed) chk("lane0_pair", {d1[0], d2[0]}, pairs[13-2*k -: 2]);
            if (k == SLOTS - 1) return;
            din_valid = 1'($urandom); din = rand_din(); pat_mode = 2'($urandom);
            en = (stop_slot >= 0 && k >= stop_slot) ? 1'b0 : 1'($urandom);
            if (k == rst_slot) begin
                rst = 1'b1; en = 1'b1; din_valid = 1'b1;
                #1;
                chk("din_ready_in_rst", din_ready, 1'b0);
                return;
            end
            #1;
            chk("din_ready_mid", din_ready, 1'b0);
        end
    endtask

    task automatic stop_and_idle(input int n);
        en = 1'b0; din_valid = 1'($urandom); din = rand_din();
        #1;
        chk("din_ready_stop", din_ready, 1'b0);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            chk_idle("idle_after_stop");
            din_valid = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = rand_din(); pat_mode = 2'd0;
        #1;
        chk("din_ready_in_rst", din_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_idle("reset_state");
        rst = 1'b0; en = 1'b0;
    endtask

    initial begin
        logic [LANES*BITS-1:0] w;
        logic [1:0]            mode;
        model_reset();
        do_reset();

        // Idle with en low stays silent.
        @(posedge clk); #1;
        chk_idle("idle_en0");

        // Directed single frame followed by three back-to-back frames.
        w = rand_din();
        w[BITS-1:0] = 14'h2D5A;
        load(1'b1, w, 2'd0);
        run_frame(-1, -1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            load(1'b1, rand_din(), 2'd0);
            run_frame(-1, -1, 1'b0);
        end

        // Underrun: second load without valid repeats the word; flag sticks.
        load(1'b0, rand_din(), 2'd0);
        run_frame(-1, -1, 1'b0);
        load(1'b1, rand_din(), 2'd0);
        run_frame(2, -1, 1'b0);
        stop_and_idle(3);

        // Reset mid-frame, then confirm a clean restart from IDLE with cleared hold.
        load(1'b1, rand_din(), 2'd0);
        run_frame(-1, 4, 1'b0);
        @(posedge clk); #1;
        model_reset();
        chk_idle("reset_mid_frame");
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk_idle("idle_after_reset");
        load(1'b0, rand_din(), 2'd0);
        run_frame(-1, -1, 1'b0);

        // Randomized frames, occasional stops.
        do_reset();
        for (int f = 0; f < 24; f++) begin
`ifdef LVDS_TX_PATTERN_EN
            mode = 2'($urandom);
`else
            mode = 2'd0;
`endif
            load(($urandom_range(0, 9) != 0), rand_din(), mode);
            run_frame(-1, -1, 1'b0);
            if ($urandom_range(0, 4) == 0) stop_and_idle($urandom_range(1, 3));
        end
        stop_and_idle(1);

`ifdef LVDS_TX_PATTERN_EN
        // Pattern source: ramp, alternate and midscale with no underrun.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            load(1'b0, rand_din(), 2'd1);
            run_frame(-1, -1, 1'b0);
        end
        for (int f = 0; f < 3; f++) begin
            load(1'b0, rand_din(), 2'd2);
            run_frame(-1, -1, 1'b0);
        end
        load(1'b0, rand_din(), 2'd3);
        run_frame(-1, -1, 1'b0);
        stop_and_idle(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
